// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : pipe_pkg                                                      |
// | Purpose  : Shared definitions for the 5-stage pipeline control blocks:   |
// |            the operand forward-select encodings, the stage-record        |
// |            control fields and the bubble constant.                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package pipe_pkg;

  // Default register-index width of the pipeline.
  localparam int REG_W = 5;

  // Forward-select encodings. The order matches the inputs of the existing
  // 3-input operand mux. 2'b11 is never produced.
  localparam logic [1:0] FWD_REG = 2'b00;  // regfile / ID-EX value
  localparam logic [1:0] FWD_WB  = 2'b01;  // WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // MEM ALU result

  // Control part of a stage record. The register-index fields are sized by
  // the RW parameter of the block that owns the record.
  typedef struct packed {
    logic regwrite;
    logic memread;
  } stage_ctl_t;

  // A bubble writes nothing and loads nothing.
  localparam stage_ctl_t CTL_BUBBLE = '{regwrite: 1'b0, memread: 1'b0};

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fwd_match                                                     |
// | Purpose  : Compares one source register index against one pipeline      |
// |            stage record.                                                |
// | Ports    : src      in  RW  source register index being read            |
// |            rd       in  RW  destination index held by the stage         |
// |            regwrite in  1   stage writes a register                     |
// |            memread  in  1   stage is a load                             |
// |            produces out 1   stage will write src (never for r0)         |
// |            is_load  out 1   produces, and the value comes from memory   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fwd_match #(
  parameter int RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic [RW-1:0] rd,
  input  logic          regwrite,
  input  logic          memread,
  output logic          produces,
  output logic          is_load
);

  // r0 is hard-wired to zero, so a write to it never creates a dependency.
  assign produces = regwrite && (rd == src) && (src != '0);
  assign is_load  = produces && memread;

endmodule : fwd_match
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fwd_hazard_unit                                               |
// | Purpose  : Forwarding and hazard controller for the 5-stage pipeline.    |
// |            Tracks the destination of the instructions in EX, MEM and WB,|
// |            drives the ALU-operand and branch-compare forward selects,   |
// |            and stalls ID (bubble into EX) on load-use and branch-       |
// |            operand hazards.                                             |
// | Ports    : clk, rst (async, active-high), hold (global freeze)          |
// |            id_rs/id_rt/id_use_rs/id_use_rt/id_branch  ID sources        |
// |            id_rd/id_regwrite/id_memread               ID destination    |
// |            fwd_a/fwd_b   ALU operand selects (registered path)          |
// |            cmp_a/cmp_b   branch compare selects (combinational)         |
// |            stall         freeze PC, IF/ID; bubble into ID/EX            |
// |            stall_cycles  saturating count of stalled cycles            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int RW = REG_W,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_branch,
  input  logic [RW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          cmp_a,
  output logic          cmp_b,
  output logic          stall,
  output logic [CW-1:0] stall_cycles
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // EX keeps its sources because the forward selects are decoded from them.
  // MEM and WB only ever act as producers, so their sources are not kept.
  typedef struct packed {
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    stage_ctl_t    ctl;
  } ex_rec_t;

  ex_rec_t       r_ex;
  logic [RW-1:0] r_mem_rd;
  stage_ctl_t    r_mem_ctl;
  logic [RW-1:0] r_wb_rd;
  logic          r_wb_regwrite;
  logic [CW-1:0] r_stall_cycles;

  // Index 0 handles rs (fwd_a / cmp_a), index 1 handles rt (fwd_b / cmp_b).
  logic [RW-1:0] w_ex_src  [2];
  logic [RW-1:0] w_id_src  [2];
  logic          w_id_use  [2];
  logic [1:0]    w_fwd     [2];
  logic          w_cmp     [2];
  logic          w_src_stall [2];

  assign w_ex_src[0] = r_ex.rs;
  assign w_ex_src[1] = r_ex.rt;
  assign w_id_src[0] = id_rs;
  assign w_id_src[1] = id_rt;
  assign w_id_use[0] = id_use_rs;
  assign w_id_use[1] = id_use_rt;

  for (genvar i = 0; i < 2; i++) begin : g_src
    logic exmem_prod, exmem_load;
    logic exwb_prod,  exwb_load;
    logic idex_prod,  idex_load;
    logic idmem_prod, idmem_load;

    fwd_match #(.RW(RW)) u_ex_mem (
      .src      (w_ex_src[i]),
      .rd       (r_mem_rd),
      .regwrite (r_mem_ctl.regwrite),
      .memread  (r_mem_ctl.memread),
      .produces (exmem_prod),
      .is_load  (exmem_load)
    );

    // WB presents the final result whether it came from the ALU or memory,
    // so its record carries no load flag.
    fwd_match #(.RW(RW)) u_ex_wb (
      .src      (w_ex_src[i]),
      .rd       (r_wb_rd),
      .regwrite (r_wb_regwrite),
      .memread  (1'b0),
      .produces (exwb_prod),
      .is_load  (exwb_load)
    );

    fwd_match #(.RW(RW)) u_id_ex (
      .src      (w_id_src[i]),
      .rd       (r_ex.rd),
      .regwrite (r_ex.ctl.regwrite),
      .memread  (r_ex.ctl.memread),
      .produces (idex_prod),
      .is_load  (idex_load)
    );

    fwd_match #(.RW(RW)) u_id_mem (
      .src      (w_id_src[i]),
      .rd       (r_mem_rd),
      .regwrite (r_mem_ctl.regwrite),
      .memread  (r_mem_ctl.memread),
      .produces (idmem_prod),
      .is_load  (idmem_load)
    );

    // A load in MEM has no ALU result to forward; the consumer was stalled
    // until the loaded value reaches WB. MEM beats WB as the younger value.
    assign w_fwd[i] = (exmem_prod && !exmem_load) ? FWD_MEM :
                      (exwb_prod  && !exwb_load)  ? FWD_WB  : FWD_REG;

    // WB needs no compare forward: the regfile writes before it is read.
    assign w_cmp[i] = id_branch && w_id_use[i] && idmem_prod && !idmem_load;

    // Load-use on EX; a branch also waits on any EX producer (no EX->ID
    // path) and on a load still in MEM.
    assign w_src_stall[i] = w_id_use[i] &&
                            (idex_load ||
                             (id_branch && idex_prod) ||
                             (id_branch && idmem_load));
  end : g_src

  assign fwd_a        = w_fwd[0];
  assign fwd_b        = w_fwd[1];
  assign cmp_a        = w_cmp[0];
  assign cmp_b        = w_cmp[1];
  assign stall        = w_src_stall[0] || w_src_stall[1];
  assign stall_cycles = r_stall_cycles;

  // The stall needs no FSM: the inserted bubble moves through EX and MEM,
  // and the hazard disappears once the producer has moved far enough on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex           <= '{rs: '0, rt: '0, rd: '0, ctl: CTL_BUBBLE};
      r_mem_rd       <= '0;
      r_mem_ctl      <= CTL_BUBBLE;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
      r_stall_cycles <= '0;
    end else if (!hold) begin
      r_wb_rd       <= r_mem_rd;
      r_wb_regwrite <= r_mem_ctl.regwrite;
      r_mem_rd      <= r_ex.rd;
      r_mem_ctl     <= r_ex.ctl;
      if (stall) begin
        r_ex <= '{rs: '0, rt: '0, rd: '0, ctl: CTL_BUBBLE};
      end else begin
        r_ex <= '{rs: id_rs, rt: id_rt, rd: id_rd,
                  ctl: '{regwrite: id_regwrite, memread: id_memread}};
      end
      if (stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_ONE;
      end
    end
  end

endmodule : fwd_hazard_unit
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fwd_hazard_unit                                            |
// | Purpose  : Scoreboard bench for fwd_hazard_unit. Stimulus pushes the     |
// |            predicted outputs of each cycle into a queue; a monitor on   |
// |            the falling edge pops and compares. Directed scenarios are   |
// |            followed by random instruction streams with random hold.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fwd_hazard_unit;

  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          hold;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          id_use_rs, id_use_rt, id_branch, id_regwrite, id_memread;
  logic [1:0]    fwd_a, fwd_b;
  logic          cmp_a, cmp_b, stall;
  logic [CW-1:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.RW(5), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_branch    (id_branch),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .cmp_a        (cmp_a),
    .cmp_b        (cmp_b),
    .stall        (stall),
    .stall_cycles (stall_cycles)
  );

  // An instruction as seen in ID.
  typedef struct packed {
    bit [4:0] rs, rt, rd;
    bit use_rs, use_rt, br, rw, mr;
  } ins_t;

  // What the model remembers about an instruction further down the pipe.
  typedef struct packed {
    bit [4:0] rs, rt, rd;
    bit rw, mr;
  } slot_t;

  typedef struct packed {
    bit [1:0] fa, fb;
    bit ca, cb, st;
    bit [CW-1:0] cnt;
  } exp_t;

  localparam ins_t NOP = '0;

  slot_t m_ex, m_mem, m_wb;
  int    m_cnt;
  exp_t  exp_q[$];

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic ins_t alu(input bit [4:0] rd, input bit [4:0] rs, input bit [4:0] rt);
    return '{rs: rs, rt: rt, rd: rd, use_rs: 1'b1, use_rt: 1'b1, br: 1'b0, rw: 1'b1, mr: 1'b0};
  endfunction

  function automatic ins_t ld(input bit [4:0] rd, input bit [4:0] rs);
    return '{rs: rs, rt: 5'd0, rd: rd, use_rs: 1'b1, use_rt: 1'b0, br: 1'b0, rw: 1'b1, mr: 1'b1};
  endfunction

  function automatic ins_t beq(input bit [4:0] rs, input bit [4:0] rt);
    return '{rs: rs, rt: rt, rd: 5'd0, use_rs: 1'b1, use_rt: 1'b1, br: 1'b1, rw: 1'b0, mr: 1'b0};
  endfunction

  // Does an older instruction deliver a new value of register r?
  function automatic bit writes(input slot_t s, input bit [4:0] r);
    return s.rw && (s.rd == r) && (r != 5'd0);
  endfunction

  // Youngest available non-memory value: MEM ALU result, then WB result.
  function automatic bit [1:0] operand_src(input bit [4:0] r);
    if (writes(m_mem, r) && !m_mem.mr) return 2'd2;
    if (writes(m_wb, r))               return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit must_wait(input ins_t i, input bit [4:0] r, input bit used);
    bit on_ex_load, on_ex_branch, on_mem_load;
    on_ex_load   = writes(m_ex, r) && m_ex.mr;
    on_ex_branch = i.br && writes(m_ex, r);
    on_mem_load  = i.br && writes(m_mem, r) && m_mem.mr;
    return used && (on_ex_load || on_ex_branch || on_mem_load);
  endfunction

  function automatic exp_t predict(input ins_t i);
    exp_t e;
    e.fa  = operand_src(m_ex.rs);
    e.fb  = operand_src(m_ex.rt);
    e.ca  = i.br && i.use_rs && writes(m_mem, i.rs) && !m_mem.mr;
    e.cb  = i.br && i.use_rt && writes(m_mem, i.rt) && !m_mem.mr;
    e.st  = must_wait(i, i.rs, i.use_rs) || must_wait(i, i.rt, i.use_rt);
    e.cnt = CW'(m_cnt);
    return e;
  endfunction

  task automatic drive(input ins_t i, input bit h);
    id_rs       = i.rs;
    id_rt       = i.rt;
    id_rd       = i.rd;
    id_use_rs   = i.use_rs;
    id_use_rt   = i.use_rt;
    id_branch   = i.br;
    id_regwrite = i.rw;
    id_memread  = i.mr;
    hold        = h;
  endtask

  // One clock: present ID, predict, then advance the model across the edge.
  task automatic step(input ins_t i, input bit h, output bit st);
    exp_t e;
    drive(i, h);
    e = predict(i);
    exp_q.push_back(e);
    st = e.st;
    @(posedge clk);
    if (!h) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = e.st ? slot_t'('0)
                   : slot_t'{rs: i.rs, rt: i.rt, rd: i.rd, rw: i.rw, mr: i.mr};
      if (e.st && m_cnt < CNTMAX) m_cnt++;
    end
    #1;
  endtask

  // Keep presenting an instruction until it is accepted into EX.
  task automatic issue(input ins_t i, output int stalls);
    bit st;
    bit done;
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 6 && !done; k++) begin
      step(i, 1'b0, st);
      if (st) stalls++;
      else    done = 1'b1;
    end
    if (!done) chk("issue_timeout", stalls, 0);
  endtask

  task automatic model_clear();
    m_ex  = '0;
    m_mem = '0;
    m_wb  = '0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    bit st;
    drive(NOP, 1'b0);
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(NOP, 1'b0, st);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("fwd_a", fwd_a, e.fa);
      chk("fwd_b", fwd_b, e.fb);
      chk("cmp_a", cmp_a, e.ca);
      chk("cmp_b", cmp_b, e.cb);
      chk("stall", stall, e.st);
      chk("stall_cycles", stall_cycles, e.cnt);
    end
  end

  initial begin
    int   n;
    bit   st;
    ins_t r;

    rst = 1'b1;
    drive(NOP, 1'b0);
    model_clear();

    // Forwarding priority, and forwarding from WB across a gap.
    do_reset();
    issue(alu(3, 1, 2), n);
    issue(alu(3, 4, 1), n);
    issue(alu(5, 3, 3), n);
    chk("prio_fwd_a", fwd_a, 2);
    chk("prio_fwd_b", fwd_b, 2);
    issue(alu(3, 1, 2), n);
    issue(NOP, n);
    issue(alu(5, 3, 3), n);
    chk("gap_fwd_a", fwd_a, 1);

    // Load-use.
    do_reset();
    issue(ld(4, 1), n);
    issue(alu(6, 4, 1), n);
    chk("lu_stalls", n, 1);
    chk("lu_fwd_a", fwd_a, 1);
    chk("lu_cnt", stall_cycles, 1);

    // Branch after ALU op.
    do_reset();
    issue(alu(7, 1, 1), n);
    issue(beq(7, 2), n);
    chk("br_alu_stalls", n, 1);
    chk("br_alu_cnt", stall_cycles, 1);

    // Branch after load.
    do_reset();
    issue(ld(7, 1), n);
    issue(beq(2, 7), n);
    chk("br_ld_stalls", n, 2);
    chk("br_ld_cnt", stall_cycles, 2);

    // r0 never forwards or stalls.
    do_reset();
    issue(ld(0, 1), n);
    issue(alu(1, 0, 0), n);
    chk("r0_stalls", n, 0);
    chk("r0_fwd_a", fwd_a, 0);
    chk("r0_cnt", stall_cycles, 0);

    // Hold during a load-use stall.
    do_reset();
    issue(ld(4, 1), n);
    repeat (3) step(alu(6, 4, 1), 1'b1, st);
    chk("hold_stall", stall, 1);
    chk("hold_cnt", stall_cycles, 0);
    issue(alu(6, 4, 1), n);
    chk("hold_release_cnt", stall_cycles, 1);

    // Reset in the middle of a stall.
    do_reset();
    issue(ld(4, 1), n);
    issue(alu(6, 4, 1), n);
    issue(ld(4, 1), n);
    drive(alu(6, 4, 1), 1'b0);
    #1;
    chk("midrst_stall_before", stall, 1);
    chk("midrst_cnt_before", stall_cycles, 1);
    rst = 1'b1;
    model_clear();
    #1;
    chk("midrst_stall", stall, 0);
    chk("midrst_cnt", stall_cycles, 0);
    chk("midrst_fwd_b", fwd_b, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(alu(6, 4, 1), 1'b0, st);

    // Counter saturation.
    do_reset();
    repeat (20) begin
      issue(ld(4, 1), n);
      issue(alu(6, 4, 1), n);
    end
    chk("sat_cnt", stall_cycles, CNTMAX);

    // Random instruction streams over a small register set.
    do_reset();
    repeat (400) begin
      r.rs     = 5'($urandom_range(0, 7));
      r.rt     = 5'($urandom_range(0, 7));
      r.rd     = 5'($urandom_range(0, 7));
      r.use_rs = ($urandom_range(0, 99) < 80);
      r.use_rt = ($urandom_range(0, 99) < 60);
      r.br     = ($urandom_range(0, 99) < 25);
      r.rw     = ($urandom_range(0, 99) < 65);
      r.mr     = r.rw && ($urandom_range(0, 99) < 40);
      step(r, ($urandom_range(0, 99) < 15), st);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fwd_hazard_unit
`default_nettype wire
